// File: rtl/vscale_inst_queue.sv
// rtl/vscale_inst_queue.sv - instruction prefetch queue between imem and decode
//
// Issues sequential word fetches, buffers returned words with their PCs in a
// DEPTH-entry FIFO and presents them in order to decode. A redirect flushes the
// FIFO, marks every response still in flight for discard and restarts fetching
// at the new PC.
//
// Optional feature macro: VSCALE_IQ_BYPASS_EN
//   When defined, a kept response arriving while the FIFO is empty drives
//   inst_valid/inst/inst_pc combinationally in the same cycle. If decode takes
//   it in that cycle, the word is never written to the FIFO.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr    fetch request handshake and word address
//   imem_resp_valid/data         in-order fetch responses
//   inst_valid/inst/inst_pc      queue head presented to decode
//   inst_ready                   decode consumes the head
//   redirect/redirect_pc         flush and restart at redirect_pc (bits [1:0] ignored)

module vscale_inst_queue #(
   parameter int                 XPR_LEN  = 32,
   parameter int                 DEPTH    = 4,
   parameter logic [XPR_LEN-1:0] RESET_PC = 'h200
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XPR_LEN-1:0] imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [XPR_LEN-1:0] imem_resp_data,
   output logic               inst_valid,
   output logic [XPR_LEN-1:0] inst,
   output logic [XPR_LEN-1:0] inst_pc,
   input  logic               inst_ready,
   input  logic               redirect,
   input  logic [XPR_LEN-1:0] redirect_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [XPR_LEN-1:0] fetch_pc;
   logic [XPR_LEN-1:0] resp_pc;
   logic [XPR_LEN-1:0] mem_data [DEPTH];
   logic [XPR_LEN-1:0] mem_pc   [DEPTH];
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      wr_ptr;
   logic [CW-1:0]      count;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      discard;

   logic [CW:0]        credit_used;
   logic               req_fire;
   logic               resp_fire;
   logic               resp_keep;
   logic               head_valid;
   logic               push;
   logic               pop;
   logic               unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Requests in flight plus buffered words never exceed DEPTH, so every
   // accepted request has a FIFO slot waiting for its response. Responses
   // marked for discard still hold a credit until they come back.
   assign credit_used    = {1'b0, count} + {1'b0, outstanding};
   // reset_n gates the request so nothing is issued while memory is held in reset.
   assign imem_req_valid = reset_n && !redirect && (credit_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;

   assign req_fire   = imem_req_valid && imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_fire  = imem_resp_valid && (outstanding != '0);
   assign resp_keep  = resp_fire && (discard == '0);
   assign head_valid = (count != '0);
   assign pop        = head_valid && inst_ready;

   always_comb begin
      inst_valid = head_valid;
      inst       = head_valid ? mem_data[rd_ptr] : '0;
      inst_pc    = head_valid ? mem_pc[rd_ptr]   : '0;
      push       = resp_keep;
`ifdef VSCALE_IQ_BYPASS_EN
      // Bypass is suppressed during a redirect: that response is being dropped.
      if (!head_valid && resp_keep && !redirect) begin
         inst_valid = 1'b1;
         inst       = imem_resp_data;
         inst_pc    = resp_pc;
         push       = !inst_ready;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else if (redirect) begin
         fetch_pc    <= {redirect_pc[XPR_LEN-1:2], 2'b00};
         resp_pc     <= {redirect_pc[XPR_LEN-1:2], 2'b00};
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         // No request can fire during a redirect. outstanding already includes
         // responses pending discard, so everything left in flight is dropped.
         outstanding <= outstanding - CW'(resp_fire);
         discard     <= outstanding - CW'(resp_fire);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XPR_LEN'(4);
         end
         // resp_pc tracks every kept word, including words taken via bypass.
         if (resp_keep) begin
            resp_pc <= resp_pc + XPR_LEN'(4);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (resp_fire && (discard != '0)) begin
            discard <= discard - CW'(1);
         end
         outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
         count       <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (push && !redirect) begin
         mem_data[wr_ptr] <= imem_resp_data;
         mem_pc[wr_ptr]   <= resp_pc;
      end
   end

   resp_without_request: assert property (
      @(posedge clk) disable iff (!reset_n) !(imem_resp_valid && (outstanding == '0))
   );

endmodule

// File: tb/tb_vscale_inst_queue.sv
// tb/tb_vscale_inst_queue.sv - directed self-checking bench for vscale_inst_queue

module tb_vscale_inst_queue;

`ifdef VSCALE_IQ_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   vscale_inst_queue dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc)
   );

   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] dlv_pc[$];
   logic [31:0] dlv_w[$];
   int          cyc;
   int          lat;
   int          n_req;
   int          n_cmp;
   int          n_mis;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_resp();
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mq_addr[0]);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   endtask

   // One clock cycle: record handshakes before the edge, then present the
   // memory response for the next cycle.
   task automatic tick();
      #1;
      if (imem_resp_valid) begin
         mq_addr.delete(0);
         mq_due.delete(0);
      end
      if (imem_req_valid && imem_req_ready) begin
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc + lat);
         n_req++;
      end
      if (inst_valid && inst_ready && !redirect) begin
         dlv_pc.push_back(inst_pc);
         dlv_w.push_back(inst);
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_resp();
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      mq_addr.delete();
      mq_due.delete();
      drive_resp();
      tick();
      tick();
   endtask

   task automatic release_reset();
      reset_n = 1'b1;
      cyc     = 0;
      n_req   = 0;
      dlv_pc.delete();
      dlv_w.delete();
      #1;
   endtask

   task automatic chk_seq(input string tag, input logic [31:0] base, input int n);
      logic [31:0] pc;
      chk({tag, "_count"}, 32'(dlv_pc.size() >= n), 32'd1);
      for (int i = 0; i < n && i < dlv_pc.size(); i++) begin
         pc = base + 32'(4 * i);
         chk({tag, "_pc"}, dlv_pc[i], pc);
         chk({tag, "_word"}, dlv_w[i], mem_word(pc));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_mis = 0; cyc = 0; lat = 1; n_req = 0;
      imem_req_ready = 1'b1; inst_ready = 1'b1;
      redirect = 1'b0; redirect_pc = '0;
      imem_resp_valid = 1'b0; imem_resp_data = '0;

      // reset values
      do_reset();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr",  imem_req_addr,  32'h200);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst",      inst,    0);
      chk("rst_inst_pc",   inst_pc, 0);

      // streaming, 1-cycle latency
      lat = 1; inst_ready = 1'b1;
      release_reset();
      chk("t1_first_req_valid", imem_req_valid, 1);
      chk("t1_first_addr",      imem_req_addr,  32'h200);
      tick();
      chk("t1_second_addr",     imem_req_addr,  32'h204);
      chk("t1_resp_cycle_valid", inst_valid, BYP);
      repeat (9) tick();
      chk("t1_delivered", dlv_pc.size(), 8 + BYP);
      chk_seq("t1", 32'h200, 8);

      // decode stalled: credit stops at DEPTH
      inst_ready = 1'b0;
      do_reset();
      release_reset();
      repeat (10) tick();
      chk("t2_nreq",       n_req, 4);
      chk("t2_req_blocked", imem_req_valid, 0);
      chk("t2_head_valid", inst_valid, 1);
      chk("t2_head_pc",    inst_pc, 32'h200);
      inst_ready = 1'b1;
      #1;
      chk("t2_blocked_pop_cycle", imem_req_valid, 0);
      tick();
      chk("t2_resume_valid", imem_req_valid, 1);
      chk("t2_resume_addr",  imem_req_addr,  32'h210);
      repeat (6) tick();
      chk_seq("t2", 32'h200, 5);

      // redirect with 3 outstanding, none arriving
      lat = 4;
      do_reset();
      release_reset();
      repeat (3) tick();
      chk("t3_req_pre", imem_req_valid, 1);
      redirect = 1'b1; redirect_pc = 32'h0000_1002;
      #1;
      chk("t3_req_during", imem_req_valid, 0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t3_inst_valid_after", inst_valid, 0);
      chk("t3_req_after",  imem_req_valid, 1);
      chk("t3_addr_after", imem_req_addr,  32'h1000);
      repeat (16) tick();
      chk_seq("t3", 32'h1000, 3);

      // redirect while a response arrives with 2 outstanding
      lat = 2;
      do_reset();
      release_reset();
      repeat (2) tick();
      chk("t4_resp_present", imem_resp_valid, 1);
      redirect = 1'b1; redirect_pc = 32'h0000_2000;
      tick();
      redirect = 1'b0;
      repeat (10) tick();
      chk_seq("t4", 32'h2000, 3);

      // fetch PC wraps at 2^32
      dlv_pc.delete(); dlv_w.delete();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      repeat (12) tick();
      chk_seq("t6_wrap", 32'hFFFF_FFF8, 4);

      // asynchronous reset mid-operation
      lat = 3; inst_ready = 1'b0;
      do_reset();
      release_reset();
      repeat (5) tick();
      chk("t5_pre_valid", inst_valid, 1);
      chk("t5_pre_pc",    inst_pc, 32'h200);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_async_valid",   inst_valid, 0);
      chk("t5_async_inst",    inst, 0);
      chk("t5_async_req",     imem_req_valid, 0);
      chk("t5_async_addr",    imem_req_addr, 32'h200);
      mq_addr.delete(); mq_due.delete();
      drive_resp();
      tick();
      tick();
      lat = 1; inst_ready = 1'b1;
      release_reset();
      chk("t5_restart_valid", imem_req_valid, 1);
      chk("t5_restart_addr",  imem_req_addr, 32'h200);
      repeat (8) tick();
      chk_seq("t5", 32'h200, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
